// File: rtl/sim_run_controller.sv
// Run controller for the RISC-V core tops: stretches reset, counts cycles/instret,
// detects end-of-test via a tohost store and enforces a cycle-count watchdog.
module sim_run_controller #(
    parameter int              RESET_CYCLES   = 4,
    parameter int              TIMEOUT_CYCLES = 1000,
    parameter int              CNT_W          = 32,
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] TOHOST_ADDR    = 32'h0000_1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_we,
    input  logic [XLEN-1:0]  mem_addr,
    input  logic [XLEN-1:0]  mem_wdata,
    input  logic             retire_valid,
    output logic             core_reset,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [XLEN-2:0]  fail_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state
);

    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [HOLD_W-1:0]  hold_cnt, hold_cnt_d;
    logic               core_reset_d, done_d, pass_d, fail_d, timeout_d;
    logic [XLEN-2:0]    fail_code_d;
    logic [CNT_W-1:0]   cycle_count_d, instret_d;
    logic               tohost_hit, wdog_hit;

    assign tohost_hit = mem_we && (mem_addr == TOHOST_ADDR) && mem_wdata[0];
    assign wdog_hit   = (TIMEOUT_CYCLES != 0) &&
                        (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        // NOTE: every target gets a hold-value default first so no path infers a latch.
        state_d       = state_q;
        hold_cnt_d    = hold_cnt;
        core_reset_d  = core_reset;
        done_d        = done;
        pass_d        = pass;
        fail_d        = fail;
        timeout_d     = timeout;
        fail_code_d   = fail_code;
        cycle_count_d = cycle_count;
        instret_d     = instret;

        case (state_q)
            ST_HOLD: begin
                if (hold_cnt == HOLD_W'(RESET_CYCLES - 1)) begin
                    state_d      = ST_RUN;
                    core_reset_d = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                // The terminating edge is still a RUN edge, so it is counted too.
                cycle_count_d = cycle_count + 1'b1;
                if (retire_valid)
                    instret_d = instret + 1'b1;
                if (tohost_hit) begin
                    done_d       = 1'b1;
                    core_reset_d = 1'b1;
                    if (mem_wdata == XLEN'(1)) begin
                        state_d = ST_PASS;
                        pass_d  = 1'b1;
                    end else begin
                        state_d     = ST_FAIL;
                        fail_d      = 1'b1;
                        fail_code_d = mem_wdata[XLEN-1:1];
                    end
                end else if (wdog_hit) begin
                    state_d      = ST_TIMEOUT;
                    timeout_d    = 1'b1;
                    done_d       = 1'b1;
                    core_reset_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_HOLD;
            hold_cnt    <= '0;
            core_reset  <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
            fail_code   <= '0;
            cycle_count <= '0;
            instret     <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt    <= hold_cnt_d;
            core_reset  <= core_reset_d;
            done        <= done_d;
            pass        <= pass_d;
            fail        <= fail_d;
            timeout     <= timeout_d;
            fail_code   <= fail_code_d;
            cycle_count <= cycle_count_d;
            instret     <= instret_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_sim_run_controller.sv
// Directed self-checking bench for sim_run_controller (RESET_CYCLES=4, TIMEOUT_CYCLES=20),
// with a second instance that has the watchdog disabled.
module tb_sim_run_controller;

    localparam int XLEN  = 32;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             mem_we;
    logic [XLEN-1:0]  mem_addr;
    logic [XLEN-1:0]  mem_wdata;
    logic             retire_valid;

    logic             core_reset, done, pass, fail, timeout;
    logic [XLEN-2:0]  fail_code;
    logic [CNT_W-1:0] cycle_count, instret;
    logic [2:0]       state;

    logic             core_reset2, done2, pass2, fail2, timeout2;
    logic [XLEN-2:0]  fail_code2;
    logic [CNT_W-1:0] cycle_count2, instret2;
    logic [2:0]       state2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sim_run_controller #(.RESET_CYCLES(4), .TIMEOUT_CYCLES(20)) dut (
        .clk(clk), .reset(reset), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .retire_valid(retire_valid),
        .core_reset(core_reset), .done(done), .pass(pass), .fail(fail),
        .timeout(timeout), .fail_code(fail_code), .cycle_count(cycle_count),
        .instret(instret), .state(state)
    );

    sim_run_controller #(.RESET_CYCLES(4), .TIMEOUT_CYCLES(0)) dut_nowdog (
        .clk(clk), .reset(reset), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .retire_valid(retire_valid),
        .core_reset(core_reset2), .done(done2), .pass(pass2), .fail(fail2),
        .timeout(timeout2), .fail_code(fail_code2), .cycle_count(cycle_count2),
        .instret(instret2), .state(state2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle on the falling edge where outputs are sampled.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        retire_valid = 1'b0;
    endtask

    task automatic store(input logic [XLEN-1:0] addr, input logic [XLEN-1:0] data);
        mem_we    = 1'b1;
        mem_addr  = addr;
        mem_wdata = data;
        step();
        idle_inputs();
    endtask

    // One reset edge, then four HOLD edges: leaves the DUT in RUN with cycle_count=0.
    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);

        // Test 1: reset values, then the HOLD stretch.
        repeat (3) step();
        check("rst_state", state, 3'd0);
        check("rst_core_reset", core_reset, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_fail", fail, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_fail_code", fail_code, 0);
        check("rst_cycle_count", cycle_count, 0);
        check("rst_instret", instret, 0);
        reset = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            step();
            check($sformatf("hold_core_reset_e%0d", e), core_reset, 1'b1);
            check($sformatf("hold_state_e%0d", e), state, 3'd0);
        end
        step();
        check("run_entry_core_reset", core_reset, 1'b0);
        check("run_entry_state", state, 3'd1);
        check("run_entry_cycle_count", cycle_count, 0);
        repeat (3) step();
        check("run_cycle_count_3", cycle_count, 3);

        // Test 2: retire on 10 of 15 cycles, then PASS; counters freeze.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            retire_valid = (i % 3 != 2);
            step();
        end
        retire_valid = 1'b0;
        check("t2_instret_pre", instret, 10);
        store(32'h0000_1000, 32'h1);
        check("t2_state", state, 3'd2);
        check("t2_pass", pass, 1'b1);
        check("t2_done", done, 1'b1);
        check("t2_core_reset", core_reset, 1'b1);
        check("t2_fail", fail, 1'b0);
        check("t2_timeout", timeout, 1'b0);
        check("t2_instret", instret, 10);
        check("t2_cycle_count", cycle_count, 16);
        retire_valid = 1'b1;
        repeat (3) step();
        store(32'h0000_1000, 32'h7);
        check("t2_instret_frozen", instret, 10);
        check("t2_cycle_frozen", cycle_count, 16);
        check("t2_state_sticky", state, 3'd2);
        check("t2_fail_after", fail, 1'b0);

        // Test 3: odd non-one value gives FAIL with code, sticky against a later PASS store.
        do_reset();
        repeat (2) step();
        store(32'h0000_1000, 32'h0000_0007);
        check("t3_state", state, 3'd3);
        check("t3_fail", fail, 1'b1);
        check("t3_fail_code", fail_code, 3);
        check("t3_pass", pass, 1'b0);
        check("t3_done", done, 1'b1);
        store(32'h0000_1000, 32'h1);
        check("t3_fail_sticky", fail, 1'b1);
        check("t3_pass_sticky", pass, 1'b0);
        check("t3_state_sticky", state, 3'd3);

        // Test 6: one reset edge while in FAIL restores reset values and restarts HOLD.
        reset = 1'b1;
        step();
        check("t6_state", state, 3'd0);
        check("t6_core_reset", core_reset, 1'b1);
        check("t6_done", done, 1'b0);
        check("t6_fail", fail, 1'b0);
        check("t6_pass", pass, 1'b0);
        check("t6_fail_code", fail_code, 0);
        check("t6_cycle_count", cycle_count, 0);
        reset = 1'b0;
        repeat (3) step();
        check("t6_hold_core_reset", core_reset, 1'b1);
        step();
        check("t6_release_core_reset", core_reset, 1'b0);
        check("t6_release_state", state, 3'd1);

        // Test 5: stores that must be ignored.
        store(32'h0000_1000, 32'h2);
        store(32'h0000_1004, 32'h1);
        mem_we = 1'b0; mem_addr = 32'h0000_1000; mem_wdata = 32'h1;
        step();
        idle_inputs();
        check("t5_state", state, 3'd1);
        check("t5_done", done, 1'b0);
        check("t5_cycle_count", cycle_count, 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        mem_we = 1'b1; mem_addr = 32'h0000_1000; mem_wdata = 32'h1;
        repeat (4) step();
        idle_inputs();
        check("t5_hold_state", state, 3'd1);
        check("t5_hold_done", done, 1'b0);
        check("t5_hold_pass", pass, 1'b0);

        // Test 4: watchdog fires after 20 RUN edges; disabled watchdog keeps running.
        do_reset();
        repeat (19) step();
        check("t4_pre_state", state, 3'd1);
        check("t4_pre_timeout", timeout, 1'b0);
        check("t4_pre_cycle", cycle_count, 19);
        step();
        check("t4_state", state, 3'd4);
        check("t4_timeout", timeout, 1'b1);
        check("t4_done", done, 1'b1);
        check("t4_core_reset", core_reset, 1'b1);
        check("t4_pass", pass, 1'b0);
        check("t4_cycle_count", cycle_count, 20);
        check("t4_nowdog_state", state2, 3'd1);
        check("t4_nowdog_done", done2, 1'b0);
        check("t4_nowdog_cycle", cycle_count2, 20);
        repeat (3) step();
        check("t4_cycle_frozen", cycle_count, 20);
        check("t4_state_sticky", state, 3'd4);

        // Test 4b: tohost PASS on the watchdog edge wins.
        do_reset();
        repeat (19) step();
        store(32'h0000_1000, 32'h1);
        check("t4b_state", state, 3'd2);
        check("t4b_pass", pass, 1'b1);
        check("t4b_timeout", timeout, 1'b0);
        check("t4b_cycle_count", cycle_count, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
